beam_thresh_loader: RTL and testbench
=====================================

# beam_thresh_loader

Threshold sequencer for a bank of `dual_pueo_beam` instances. It holds a shadow copy of one 18-bit power threshold per beam, written from the control side. On a commit, or automatically after reset, it serially loads every beam's threshold, as a two's-complement value, onto the shared `thresh` bus and its per-beam `thresh_ce` strobe. It then broadcasts a single `update` pulse so all DSP thresholds switch on the same clock.

## Interface
Parameters:
- `NBEAM`, 48: number of beams; must be even. Instance k uses beams 2k (A) and 2k+1 (B).
- `THRESH_DEFAULT`, 18'd20000: shadow value after reset (positive magnitude).

Ports:
- `clk_i` input 1: trigger-domain clock.
- `rst_ni` input 1: reset; asynchronous, active-low.
- `wr_valid_i` input 1: shadow write request.
- `wr_ready_o` output 1: write accepted when `wr_valid_i & wr_ready_o`.
- `wr_addr_i` input $clog2(NBEAM): beam index.
- `wr_data_i` input 18: unsigned threshold magnitude.
- `commit_i` input 1: level-sampled request to load all shadows into the DSPs.
- `busy_o` output 1: a load sequence is in progress.
- `done_o` output 1: one-cycle pulse when a sequence completes.
- `thresh_o` output 18: shared DSP threshold bus.
- `thresh_ce_o` output NBEAM: one-hot load strobe. Bits [2k+1:2k] map to instance k's `thresh_ce_i[1:0]`.
- `update_o` output 1: broadcast to every instance's `update_i`.

## Operation
- States: INIT, IDLE, LOAD, UPDATE, DONE.
- Reset (async, `rst_ni`=0):
  - All shadows are set to `THRESH_DEFAULT`.
  - State is INIT and the index is 0.
  - `thresh_o`=0, `thresh_ce_o`=0, `update_o`=0, `done_o`=0.
  - `busy_o`=1 and `wr_ready_o`=0.
  - The pending flag is cleared.
- INIT → LOAD on the first clock after reset release. The power-up load is implicit and needs no commit.
- IDLE:
  - `wr_ready_o`=1.
  - An accepted write with `wr_addr_i` < NBEAM updates that shadow. A write with an address ≥ NBEAM is accepted and discarded.
  - `commit_i`=1 → LOAD.
  - A write and a commit in the same cycle: the write lands first, so the new value is included in the load.
- LOAD:
  - For idx = 0…NBEAM-1, one per cycle: `thresh_o` = (2^18 − shadow[idx]) mod 2^18, and `thresh_ce_o` = 1<<idx.
  - A shadow value of 0 yields `thresh_o`=0.
- UPDATE: `thresh_ce_o`=0 and `update_o`=1 for exactly one cycle.
- DONE:
  - `done_o`=1 for one cycle.
  - Goes to LOAD if pending, clearing pending; otherwise to IDLE.
- Writes are refused (`wr_ready_o`=0) in every state except IDLE. The shadow array therefore never changes mid-sequence.
- `commit_i` while not in IDLE sets pending. Only one pending request is held; further commits merge into it.
- Reset mid-sequence: all outputs drop immediately. Shadows revert to default, and a full INIT load follows.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Commit sampled at edge t in IDLE:
  - `busy_o`=1 from t+1.
  - `thresh_ce_o` bit i is set at t+1+i.
  - `update_o` pulses at t+NBEAM+1.
  - `done_o` pulses at t+NBEAM+2.
  - `busy_o` drops at t+NBEAM+2 when nothing is pending.
  - `wr_ready_o`=1 from t+NBEAM+3.
- Sequence length: NBEAM+2 cycles from first strobe to `done_o`.
- `thresh_o` is valid in the same cycle as its `thresh_ce_o` bit. Outside LOAD, `thresh_o` holds its last value.
- Pending re-run: LOAD starts the cycle after DONE, with `busy_o` staying high.
- Exactly one `thresh_ce_o` bit is high in any cycle during LOAD, and none are high otherwise.
- `update_o` is never high in the same cycle as any `thresh_ce_o` bit.

## Structure
- `beam_thresh_pkg`:
  - `THRESH_BITS`=18.
  - State enum `thresh_state_t`.
  - Function `to_dsp_thresh(logic [17:0])` returning the 18-bit two's complement.
- Sub-module `beam_thresh_shadow`:
  - NBEAM×18 register file with a write port and an async read port indexed by idx.
  - Reset loads `THRESH_DEFAULT`.
  - Distributed RAM is not allowed, because of the reset requirement.
- The top level holds the FSM, idx counter, pending flag and output registers.

## Test plan
- Reset release with no writes:
  - One full sequence runs from INIT.
  - Every strobe carries `thresh_o`=18'h3B1E0 (2^18−20000).
  - `update_o` pulses once, then `done_o` pulses once, then `busy_o`=0.
- Write addr 3 = 18'd1000, then commit:
  - The cycle with `thresh_ce_o`[3]=1 has `thresh_o`=18'h3FC18.
  - Every other beam shows 18'h3B1E0.
  - `update_o` occurs exactly NBEAM+1 cycles after the commit edge.
- Commit held during busy, plus a second commit:
  - Exactly one extra sequence runs, back-to-back with no IDLE cycle.
  - Total `done_o` pulses = 2.
- Write attempted during LOAD (`wr_valid_i`=1, addr 5 = 18'd7):
  - `wr_ready_o`=0 throughout.
  - A later commit still shows the old value at beam 5.
  - The write completes only once back in IDLE.
- Edge values and address range:
  - Shadow 0 → `thresh_o`=0.
  - Shadow 18'h3FFFF → `thresh_o`=18'h00001.
  - A write to addr NBEAM is accepted and changes no shadow.
- Assert `rst_ni`=0 mid-LOAD at idx=10:
  - Outputs are zero asynchronously.
  - After release, a full INIT sequence from idx 0 carries default values.

Source files
------------

// File: rtl/beam_thresh_pkg.sv
// rtl/beam_thresh_pkg.sv - shared types and helpers for the beam threshold loader
package beam_thresh_pkg;

    localparam int THRESH_BITS = 18;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } thresh_state_t;

    // The DSP compares against a negated threshold, so magnitudes are loaded as
    // their two's complement; a zero magnitude stays zero.
    function automatic logic [THRESH_BITS-1:0] to_dsp_thresh(input logic [THRESH_BITS-1:0] mag);
        return (~mag) + {{(THRESH_BITS-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/beam_thresh_shadow.sv
// rtl/beam_thresh_shadow.sv - per-beam shadow threshold register file
module beam_thresh_shadow
    import beam_thresh_pkg::*;
#(
    parameter int                     NBEAM          = 48,
    parameter logic [THRESH_BITS-1:0] THRESH_DEFAULT = 18'd20000,
    parameter int                     AW             = $clog2(NBEAM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [THRESH_BITS-1:0] wr_data,
    input  logic [AW-1:0]          rd_addr,
    output logic [THRESH_BITS-1:0] rd_data
);

    // Flop-based so every entry can be forced back to the default on reset.
    logic [THRESH_BITS-1:0] mem [NBEAM];

    // Shadow storage: reset to default, otherwise single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBEAM; i++) begin
                mem[i] <= THRESH_DEFAULT;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/beam_thresh_loader.sv
// rtl/beam_thresh_loader.sv - serial threshold loader for a bank of dual_pueo_beam DSPs
module beam_thresh_loader
    import beam_thresh_pkg::*;
#(
    parameter int                     NBEAM          = 48,
    parameter logic [THRESH_BITS-1:0] THRESH_DEFAULT = 18'd20000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [$clog2(NBEAM)-1:0]  wr_addr_i,
    input  logic [THRESH_BITS-1:0]    wr_data_i,
    input  logic                      commit_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [THRESH_BITS-1:0]    thresh_o,
    output logic [NBEAM-1:0]          thresh_ce_o,
    output logic                      update_o
);

    localparam int              AW       = $clog2(NBEAM);
    localparam logic [AW-1:0]   LAST_IDX = AW'(NBEAM - 1);
    localparam logic [AW-1:0]   IDX_ONE  = AW'(1);
    localparam logic [NBEAM-1:0] CE_FIRST = NBEAM'(1);

    thresh_state_t          state;
    logic [AW-1:0]          idx;
    logic [AW-1:0]          rd_idx;
    logic                   pending;
    logic                   wr_fire;
    logic                   wr_hit;
    logic                   start;
    logic [THRESH_BITS-1:0] rd_data;
    logic [THRESH_BITS-1:0] first_mag;

    assign wr_fire = wr_valid_i & wr_ready_o;
    // Out-of-range addresses complete the handshake but never touch storage.
    assign wr_hit  = wr_fire & (32'(wr_addr_i) < NBEAM);

    beam_thresh_shadow #(
        .NBEAM          (NBEAM),
        .THRESH_DEFAULT (THRESH_DEFAULT),
        .AW             (AW)
    ) u_shadow (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .wr_en   (wr_hit),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // Read one beam ahead of the strobe so the output register holds the current beam.
    always_comb begin
        rd_idx = '0;
        if (state == ST_LOAD && idx != LAST_IDX) begin
            rd_idx = idx + IDX_ONE;
        end
    end

    // Beam 0 is registered on the starting edge; a same-cycle write to it must be seen.
    always_comb begin
        first_mag = rd_data;
        if (wr_hit && wr_addr_i == '0) begin
            first_mag = wr_data_i;
        end
    end

    // A sequence begins after reset, on an idle commit, or on a queued commit at DONE.
    always_comb begin
        start = 1'b0;
        case (state)
            ST_INIT: start = 1'b1;
            ST_IDLE: start = commit_i;
            ST_DONE: start = pending | commit_i;
            default: start = 1'b0;
        endcase
    end

    // Sequencer: state, beam index, pending request and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_INIT;
            idx         <= '0;
            pending     <= 1'b0;
            thresh_o    <= '0;
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b1;
            wr_ready_o  <= 1'b0;
        end else begin
            update_o <= 1'b0;
            done_o   <= 1'b0;

            if (state != ST_IDLE && commit_i) begin
                pending <= 1'b1;
            end

            if (start) begin
                state       <= ST_LOAD;
                idx         <= '0;
                thresh_ce_o <= CE_FIRST;
                thresh_o    <= to_dsp_thresh(first_mag);
                busy_o      <= 1'b1;
                wr_ready_o  <= 1'b0;
                if (state == ST_DONE) begin
                    pending <= 1'b0;
                end
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (idx == LAST_IDX) begin
                            state       <= ST_UPDATE;
                            thresh_ce_o <= '0;
                            update_o    <= 1'b1;
                        end else begin
                            idx         <= idx + IDX_ONE;
                            thresh_ce_o <= thresh_ce_o << 1;
                            thresh_o    <= to_dsp_thresh(rd_data);
                        end
                    end
                    ST_UPDATE: begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                        busy_o <= pending | commit_i;
                    end
                    ST_DONE: begin
                        state      <= ST_IDLE;
                        busy_o     <= 1'b0;
                        wr_ready_o <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beam_thresh_loader.sv
// tb/tb_beam_thresh_loader.sv - self-checking bench for beam_thresh_loader
module tb_beam_thresh_loader;

    localparam int NBEAM = 48;
    localparam int AW    = $clog2(NBEAM);
    localparam int DEF   = 20000;
    localparam int FULL  = 262144;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic              wr_valid = 1'b0;
    logic              commit   = 1'b0;
    logic [AW-1:0]     wr_addr  = '0;
    logic [17:0]       wr_data  = '0;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic              update;
    logic [17:0]       thresh;
    logic [NBEAM-1:0]  thresh_ce;

    beam_thresh_loader #(
        .NBEAM          (NBEAM),
        .THRESH_DEFAULT (18'd20000)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .commit_i    (commit),
        .busy_o      (busy),
        .done_o      (done),
        .thresh_o    (thresh),
        .thresh_ce_o (thresh_ce),
        .update_o    (update)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int model [NBEAM];
    int seen  [NBEAM];
    int cap_n = 0;
    int n_done = 0;
    int n_update = 0;
    int first_ce_cyc = -1;
    int update_cyc = -1;
    int done_cyc = -1;
    int prev_done_cyc = -1;
    logic busy_at_done = 1'b0;

    typedef struct {
        int addr;
        int data;
        int chk_idx;
        int exp;
    } vec_t;

    vec_t vecs [6];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int exp_dsp(input int s);
        return (FULL - s) % FULL;
    endfunction

    function automatic int ce_index(input logic [NBEAM-1:0] v);
        for (int i = 0; i < NBEAM; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: every strobe is checked against the model; sequence events are time-stamped.
    always @(negedge clk) begin
        if (!rst_n) begin
            cap_n = 0;
        end else begin
            if (thresh_ce != '0) begin
                chk("strobe_onehot", $countones(thresh_ce), 1);
                chk("strobe_update_overlap", int'(update), 0);
                chk("strobe_order", ce_index(thresh_ce), cap_n);
                if (cap_n < NBEAM) begin
                    chk($sformatf("thresh_beam%0d", cap_n), int'(thresh), exp_dsp(model[cap_n]));
                    seen[cap_n] = int'(thresh);
                end
                if (cap_n == 0) first_ce_cyc = cyc;
                cap_n++;
            end
            if (update) begin
                n_update++;
                update_cyc = cyc;
            end
            if (done) begin
                chk("seq_length", cap_n, NBEAM);
                cap_n = 0;
                n_done++;
                prev_done_cyc = done_cyc;
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 500; i++) begin
            if (n_done >= target) break;
            @(posedge clk);
            #1;
        end
        chk("done_timeout", int'(n_done >= target), 1);
    endtask

    task automatic do_write(input int addr, input int data, input bit with_commit);
        bit ok;
        bit rdy;
        ok = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = AW'(addr);
        wr_data  = 18'(data);
        commit   = with_commit;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = wr_ready;
            @(posedge clk);
            #1;
            commit = 1'b0;
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        chk("write_accept_timeout", int'(ok), 1);
        if (ok && addr < NBEAM) model[addr] = data;
    endtask

    task automatic commit_seq(input bit timing);
        int t;
        int target;
        target = n_done + 1;
        commit = 1'b1;
        t = cyc + 1;
        @(posedge clk);
        #1;
        commit = 1'b0;
        wait_done(target);
        if (timing) begin
            chk("first_strobe_lat", first_ce_cyc - t, 0);
            chk("update_lat", update_cyc - t, NBEAM);
            chk("done_lat", done_cyc - t, NBEAM + 1);
            chk("busy_at_done", int'(busy_at_done), 0);
            chk("ready_return", int'(wr_ready), 1);
            chk("ready_return_lat", cyc - t, NBEAM + 2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int old5;
        int target;
        int bad;
        bit hit;

        for (int i = 0; i < NBEAM; i++) begin
            model[i] = DEF;
            seen[i]  = -1;
        end

        vecs[0] = '{addr: 3,         data: 1000,     chk_idx: 3,         exp: 'h3FC18};
        vecs[1] = '{addr: 0,         data: 0,        chk_idx: 0,         exp: 0};
        vecs[2] = '{addr: NBEAM - 1, data: 'h3FFFF,  chk_idx: NBEAM - 1, exp: 1};
        vecs[3] = '{addr: NBEAM,     data: 123,      chk_idx: 0,         exp: 0};
        vecs[4] = '{addr: 20,        data: 20001,    chk_idx: 20,        exp: FULL - 20001};
        vecs[5] = '{addr: 4,         data: 'h20000,  chk_idx: 4,         exp: 'h20000};

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 1);
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_thresh", int'(thresh), 0);
        chk("rst_ce", int'(thresh_ce != '0), 0);
        chk("rst_update", int'(update), 0);
        chk("rst_done", int'(done), 0);

        // Power-up load without any commit
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done(1);
        chk("init_update_count", n_update, 1);
        chk("init_done_count", n_done, 1);
        chk("init_busy_low", int'(busy), 0);
        chk("init_beam7", seen[7], 'h3B1E0);

        // Table of single writes followed by a commit
        for (int v = 0; v < 6; v++) begin
            do_write(vecs[v].addr, vecs[v].data, 1'b0);
            commit_seq(1'b1);
            chk($sformatf("vec%0d_beam%0d", v, vecs[v].chk_idx), seen[vecs[v].chk_idx], vecs[v].exp);
            if (v == 0) chk("vec0_beam2_default", seen[2], 'h3B1E0);
        end

        // Write and commit in the same cycle: the write is part of the load
        do_write(0, 'h400, 1'b1);
        wait_done(n_done + 1);
        chk("same_cycle_write_beam0", seen[0], FULL - 'h400);

        // Commit held during busy plus a second commit: one back-to-back re-run
        target = n_done + 2;
        commit = 1'b1;
        repeat (10) @(posedge clk);
        #1 commit = 1'b0;
        repeat (5) @(posedge clk);
        #1 commit = 1'b1;
        @(posedge clk);
        #1 commit = 1'b0;
        wait_done(target);
        chk("rerun_back_to_back", done_cyc - prev_done_cyc, NBEAM + 2);
        repeat (80) @(posedge clk);
        #1;
        chk("rerun_done_total", n_done, target);

        // Write attempted during LOAD is held off until IDLE
        old5 = model[5];
        target = n_done + 2;
        commit = 1'b1;
        @(posedge clk);
        #1 commit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_addr  = AW'(5);
        wr_data  = 18'd7;
        commit   = 1'b1;
        @(posedge clk);
        #1 commit = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (n_done >= target) break;
            if (wr_ready) bad++;
            @(posedge clk);
            #1;
        end
        chk("ready_low_while_busy", bad, 0);
        chk("held_write_done_count", int'(n_done >= target), 1);
        chk("held_write_old_beam5", seen[5], exp_dsp(old5));
        chk("ready_back_in_idle", int'(wr_ready), 1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        model[5] = 7;
        commit_seq(1'b1);
        chk("held_write_new_beam5", seen[5], 'h3FFF9);

        // Randomized writes against the model
        for (int it = 0; it < 15; it++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                do_write($urandom_range(0, (1 << AW) - 1), $urandom_range(0, FULL - 1), 1'b0);
            end
            commit_seq(it < 3);
        end

        // Reset asserted mid-LOAD at beam 10
        commit = 1'b1;
        @(posedge clk);
        #1 commit = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (thresh_ce[10]) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("reach_beam10", int'(hit), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_thresh", int'(thresh), 0);
        chk("midrst_ce", int'(thresh_ce != '0), 0);
        chk("midrst_update", int'(update), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_ready", int'(wr_ready), 0);
        for (int i = 0; i < NBEAM; i++) model[i] = DEF;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_done(n_done + 1);
        chk("after_rst_beam0", seen[0], 'h3B1E0);
        chk("after_rst_beam10", seen[10], 'h3B1E0);
        chk("after_rst_beam5", seen[5], 'h3B1E0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
